// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported data memory.
// Each granted access is held for WAIT_CYCLES cycles and then acknowledged.
module mem_arbiter #(
    parameter int WAIT_CYCLES = 3,
    parameter int BASE_ADDR   = 1024,
    parameter int DEPTH_WORDS = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        we0,
    input  logic [31:0] addr0,
    input  logic [31:0] wdata0,
    output logic        ready0,
    output logic        err0,
    output logic [31:0] rdata0,
    input  logic        req1,
    input  logic        we1,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata1,
    output logic        ready1,
    output logic        err1,
    output logic [31:0] rdata1,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    localparam logic [32:0] LOW_LIMIT  = 33'(BASE_ADDR);
    localparam logic [32:0] HIGH_LIMIT = 33'(BASE_ADDR) + 33'(4 * DEPTH_WORDS);
    localparam logic [3:0]  WAIT_INIT  = 4'(WAIT_CYCLES);

    state_t      state;
    state_t      nextState;
    logic [3:0]  count;
    logic        grantPort;
    logic        lastGrant;
    logic        weLat;
    logic        errLat;
    logic [31:0] addrLat;
    logic [31:0] wdataLat;

    logic        anyReq;
    logic        selPort;
    logic        selWe;
    logic [31:0] selAddr;
    logic [31:0] selWdata;
    logic        addrErr;
    logic        finalCycle;

    // lastGrant is the port served most recently; on a tie the other port wins.
    always_comb begin
        anyReq   = req0 | req1;
        selPort  = (req0 && req1) ? ~lastGrant : req1;
        selWe    = selPort ? we1 : we0;
        selAddr  = selPort ? addr1 : addr0;
        selWdata = selPort ? wdata1 : wdata0;
        addrErr  = ({1'b0, selAddr} < LOW_LIMIT) ||
                   ({1'b0, selAddr} >= HIGH_LIMIT) ||
                   (selAddr[1:0] != 2'b00);
        finalCycle = (count == 4'd1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        ready0    = 1'b0;
        ready1    = 1'b0;
        err0      = 1'b0;
        err1      = 1'b0;
        case (state)
            IDLE: begin
                if (anyReq) begin
                    nextState = addrErr ? DONE : ACCESS;
                end
            end
            ACCESS: begin
                mem_addr = addrLat;
                if (weLat) begin
                    mem_wdata = wdataLat;
                    mem_write = finalCycle;
                end else begin
                    mem_read = 1'b1;
                end
                if (finalCycle) begin
                    nextState = DONE;
                end
            end
            DONE: begin
                ready0    = ~grantPort;
                ready1    = grantPort;
                err0      = errLat & ~grantPort;
                err1      = errLat & grantPort;
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Transaction latches, wait counter and per-port read data registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count     <= 4'd0;
            grantPort <= 1'b0;
            lastGrant <= 1'b1;
            weLat     <= 1'b0;
            errLat    <= 1'b0;
            addrLat   <= 32'd0;
            wdataLat  <= 32'd0;
            rdata0    <= 32'd0;
            rdata1    <= 32'd0;
        end else if (state == IDLE && anyReq) begin
            grantPort <= selPort;
            lastGrant <= selPort;
            weLat     <= selWe;
            errLat    <= addrErr;
            addrLat   <= selAddr;
            wdataLat  <= selWdata;
            count     <= addrErr ? 4'd0 : WAIT_INIT;
            if (addrErr && !selWe) begin
                if (selPort) begin
                    rdata1 <= 32'd0;
                end else begin
                    rdata0 <= 32'd0;
                end
            end
        end else if (state == ACCESS) begin
            count <= count - 4'd1;
            if (finalCycle && !weLat) begin
                if (grantPort) begin
                    rdata1 <= mem_rdata;
                end else begin
                    rdata0 <= mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: drivers queue expected completions,
// a negedge monitor checks every ready pulse and every memory strobe.
module tb_mem_arbiter;

    localparam int WAIT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [31:0] addr0 = 32'd0, wdata0 = 32'd0, addr1 = 32'd0, wdata1 = 32'd0;
    logic        ready0, err0, ready1, err1;
    logic [31:0] rdata0, rdata1;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic [31:0] memModel [0:15];

    mem_arbiter #(
        .WAIT_CYCLES(WAIT),
        .BASE_ADDR(1024),
        .DEPTH_WORDS(4096)
    ) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .ready0(ready0), .err0(err0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .ready1(ready1), .err1(err1), .rdata1(rdata1),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    assign mem_rdata = memModel[mem_addr[5:2]];
    always @(posedge clk) begin
        if (mem_write) memModel[mem_addr[5:2]] <= mem_wdata;
    end

    typedef struct {
        int          port;
        logic        err;
        logic [31:0] rdata;
        int          cycle;
        int          reads;
        int          writes;
        logic [31:0] addr;
        logic [31:0] wdata;
    } exp_t;

    exp_t expQ[$];
    int checkCount = 0;
    int failCount = 0;
    int readCnt = 0;
    int writeCnt = 0;
    int lastWriteCyc = -1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checkCount++;
        if (act !== req) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: compares strobes against the head transaction and pops on ready.
    always @(negedge clk) begin : monitor
        exp_t e;
        int   port;
        if (rst) begin
            readCnt  = 0;
            writeCnt = 0;
        end else begin
            if (mem_read || mem_write) begin
                if (expQ.size() == 0) begin
                    checkOutput("strobe_without_txn", 32'd1, 32'd0);
                end else begin
                    checkOutput("mem_addr", mem_addr, expQ[0].addr);
                    if (mem_write) checkOutput("mem_wdata", mem_wdata, expQ[0].wdata);
                end
                if (mem_read) readCnt++;
                if (mem_write) begin
                    writeCnt++;
                    lastWriteCyc = cyc;
                end
            end
            if (ready0 || ready1) begin
                if (ready0 && ready1) checkOutput("both_ready", 32'd1, 32'd0);
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_ready", 32'd1, 32'd0);
                end else begin
                    e    = expQ.pop_front();
                    port = ready1 ? 1 : 0;
                    checkOutput("ready_port", 32'(port), 32'(e.port));
                    checkOutput("ready_cycle", 32'(cyc), 32'(e.cycle));
                    checkOutput("err", {31'd0, (port == 1) ? err1 : err0}, {31'd0, e.err});
                    checkOutput("rdata", (port == 1) ? rdata1 : rdata0, e.rdata);
                    checkOutput("read_strobes", 32'(readCnt), 32'(e.reads));
                    checkOutput("write_strobes", 32'(writeCnt), 32'(e.writes));
                    if (e.writes == 1) checkOutput("write_cycle", 32'(lastWriteCyc), 32'(cyc - 1));
                end
                readCnt  = 0;
                writeCnt = 0;
            end
        end
    end

    task automatic drive(input int port, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
        if (port == 0) begin
            req0 = r; we0 = w; addr0 = a; wdata0 = d;
        end else begin
            req1 = r; we1 = w; addr1 = a; wdata1 = d;
        end
    endtask

    task automatic pushExp(input int port, input logic err, input logic [31:0] rd,
                           input int cycle, input int reads, input int writes,
                           input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        e.port = port; e.err = err; e.rdata = rd; e.cycle = cycle;
        e.reads = reads; e.writes = writes; e.addr = a; e.wdata = d;
        expQ.push_back(e);
    endtask

    task automatic waitReady(input int port, input int n);
        int seen = 0;
        for (int i = 0; i < 60 * n && seen < n; i++) begin
            @(negedge clk);
            if ((port == 0 && ready0) || (port == 1 && ready1)) seen++;
        end
        if (seen < n) checkOutput("ready_timeout", 32'(seen), 32'(n));
    endtask

    // One isolated transaction: request at cycle T, expected ready at T+1 or T+WAIT+1.
    task automatic applyStimulus(input int port, input logic w, input logic [31:0] a,
                                 input logic [31:0] d, input logic expErr,
                                 input logic [31:0] expRd, input int expReads,
                                 input int expWrites);
        @(posedge clk);
        #1;
        pushExp(port, expErr, expRd, cyc + (expErr ? 1 : WAIT + 1), expReads, expWrites, a, d);
        drive(port, 1'b1, w, a, d);
        waitReady(port, 1);
        drive(port, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic holdRequests(input int port, input logic [31:0] a, input int n);
        drive(port, 1'b1, 1'b0, a, 32'd0);
        waitReady(port, n);
        drive(port, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic checkResetState();
        checkOutput("rst_ready0", {31'd0, ready0}, 32'd0);
        checkOutput("rst_ready1", {31'd0, ready1}, 32'd0);
        checkOutput("rst_err0", {31'd0, err0}, 32'd0);
        checkOutput("rst_err1", {31'd0, err1}, 32'd0);
        checkOutput("rst_mem_read", {31'd0, mem_read}, 32'd0);
        checkOutput("rst_mem_write", {31'd0, mem_write}, 32'd0);
        checkOutput("rst_mem_addr", mem_addr, 32'd0);
        checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
        checkOutput("rst_rdata0", rdata0, 32'd0);
        checkOutput("rst_rdata1", rdata1, 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t;
        for (int i = 0; i < 16; i++) memModel[i] = 32'h1000 + 32'(i);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkResetState();
        @(negedge clk);
        rst = 1'b0;

        // Writes, reads and write-leaves-rdata-unchanged.
        applyStimulus(0, 1'b1, 32'd1024, 32'd55, 1'b0, 32'd0, 0, 1);
        checkOutput("mem_word0", memModel[0], 32'd55);
        applyStimulus(1, 1'b1, 32'd1028, 32'hFFFF_FFF9, 1'b0, 32'd0, 0, 1);
        applyStimulus(1, 1'b0, 32'd1028, 32'd0, 1'b0, 32'hFFFF_FFF9, 3, 0);
        applyStimulus(0, 1'b0, 32'd1024, 32'd0, 1'b0, 32'd55, 3, 0);
        applyStimulus(0, 1'b1, 32'd1032, 32'd99, 1'b0, 32'd55, 0, 1);
        checkOutput("mem_word2", memModel[2], 32'd99);

        // Address errors: below base, misaligned, past the top, errored write.
        applyStimulus(0, 1'b0, 32'd1000, 32'd0, 1'b1, 32'd0, 0, 0);
        applyStimulus(0, 1'b0, 32'd1026, 32'd0, 1'b1, 32'd0, 0, 0);
        applyStimulus(0, 1'b0, 32'd17408, 32'd0, 1'b1, 32'd0, 0, 0);
        applyStimulus(1, 1'b1, 32'd1020, 32'd7, 1'b1, 32'hFFFF_FFF9, 0, 0);

        // Fresh reset, then both ports held: 0,1,0,1 alternation.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        t = cyc;
        pushExp(0, 1'b0, 32'd55, t + 4, 3, 0, 32'd1024, 32'd0);
        pushExp(1, 1'b0, 32'hFFFF_FFF9, t + 9, 3, 0, 32'd1028, 32'd0);
        pushExp(0, 1'b0, 32'd55, t + 14, 3, 0, 32'd1024, 32'd0);
        pushExp(1, 1'b0, 32'hFFFF_FFF9, t + 19, 3, 0, 32'd1028, 32'd0);
        fork
            holdRequests(0, 32'd1024, 2);
            holdRequests(1, 32'd1028, 2);
        join

        // Reset in the middle of a port 1 write aborts it.
        @(posedge clk);
        #1;
        drive(1, 1'b1, 1'b1, 32'd1036, 32'd123);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkResetState();
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (4) @(posedge clk);
        checkOutput("aborted_write", memModel[3], 32'h1003);
        @(negedge clk);
        rst = 1'b0;

        // After release port 0 wins a simultaneous request.
        @(posedge clk);
        #1;
        t = cyc;
        pushExp(0, 1'b0, 32'd99, t + 4, 3, 0, 32'd1032, 32'd0);
        pushExp(1, 1'b0, 32'd55, t + 9, 3, 0, 32'd1024, 32'd0);
        fork
            holdRequests(0, 32'd1032, 1);
            holdRequests(1, 32'd1024, 1);
        join

        repeat (5) @(posedge clk);
        checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WAIT_CYCLES, default 3, is the number of cycles a memory access is held; legal range 1..15.
REQ-002 Parameter BASE_ADDR, default 1024, is the byte address of memory word 0.
REQ-003 Parameter DEPTH_WORDS, default 4096, is the number of 32-bit memory words.
REQ-004 clk  in  1  single system clock; all state changes on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 req0 / req1  in  1  access request from requester 0 (CPU MEM stage) / requester 1 (debug/DMA); held until that port's ready.
REQ-007 we0 / we1  in  1  1 = write, 0 = read; stable while req high.
REQ-008 addr0 / addr1  in  32  byte address; stable while req high.
REQ-009 wdata0 / wdata1  in  32  signed write data; stable while req high.
REQ-010 ready0 / ready1  out  1  one-cycle completion pulse.
REQ-011 err0 / err1  out  1  valid with ready; 1 = address rejected.
REQ-012 rdata0 / rdata1  out  32  read data; valid with ready, held until that port's next completion.
REQ-013 mem_read / mem_write  out  1  strobes to the data memory.
REQ-014 mem_addr / mem_wdata  out  32  address and write data to the data memory.
REQ-015 mem_rdata  in  32  combinational read data from the data memory.

Function
REQ-016 The FSM SHALL have states IDLE, ACCESS, DONE.
REQ-017 IDLE: with any req sampled high, grant one port, latch its we/addr/wdata, go to ACCESS, or DONE on address error.
REQ-018 Arbitration SHALL be round-robin: sole requester wins; both requesting -> port not granted last wins; after reset port 0 wins first.
REQ-019 Address error = addr < BASE_ADDR, or addr >= BASE_ADDR + 4*DEPTH_WORDS, or addr[1:0] != 0; errored access issues no memory strobe.
REQ-020 ACCESS SHALL last exactly WAIT_CYCLES cycles, counted by a down-counter loaded at grant.
REQ-021 During ACCESS, mem_addr = latched address; on read, mem_read = 1 in every ACCESS cycle; on write, mem_wdata = latched data and mem_write = 1 only in the final ACCESS cycle (exactly one write per transaction).
REQ-022 Read data SHALL be captured from mem_rdata at the final ACCESS cycle edge into the granted port's rdata.
REQ-023 Outside ACCESS, mem_read = mem_write = 0 and mem_addr = mem_wdata = 0.
REQ-024 DONE: assert granted port's ready for one cycle with err; other port's ready = 0; next state IDLE.
REQ-025 Latency: req sampled in IDLE at cycle T -> ready at T+WAIT_CYCLES+1 (error: T+1); next grant no earlier than T+WAIT_CYCLES+2.
REQ-026 req still high in the IDLE cycle after ready SHALL be treated as a new request.
REQ-027 A write transaction SHALL leave the port's rdata unchanged; an errored read SHALL set rdata to 0.
REQ-028 The ungranted port's request SHALL wait without loss; no port starves beyond one transaction of the other.

Reset
REQ-029 On rst high, immediately and regardless of clock: state IDLE, counter 0, round-robin pointer favouring port 0, all ready/err/strobes 0, mem_addr/mem_wdata 0, rdata0/rdata1 0.
REQ-030 Reset during ACCESS SHALL abort the transaction with no ready pulse and no further memory strobe.

Verification
REQ-031 Port 0 write addr 1024 data 55, WAIT_CYCLES=3 -> mem_write high exactly one cycle (T+3), ready0 at T+4, err0=0.
REQ-032 Port 1 read addr 1028 after memory word 1 holds -7 -> mem_read high T+1..T+3, ready1 at T+4 with rdata1=-7.
REQ-033 req0 and req1 raised same cycle after reset, both held -> port 0 served first, port 1 granted in the IDLE cycle after ready0; repeated -> strict alternation.
REQ-034 Port 0 read addr 1000, then addr 1026, then 1024+16384 -> each ready0 at T+1 with err0=1, rdata0=0, no strobe.
REQ-035 rst asserted mid-ACCESS of a port 1 write -> strobes drop asynchronously, no ready1, no memory write; after release port 0 wins a simultaneous request.
